arm_mc_controller: RTL and testbench
====================================

Name: arm_mc_controller

Overview:
- Multicycle control unit for the ARM-subset datapath: PC register, instruction ROM/memory, register file, extender, ALU and their select muxes.
- Sequences each instruction through a Moore FSM and drives every mux select and write enable.
- Holds the NZCV flags register and evaluates the condition field, so execution is conditional.
- Sits beside the datapath top and replaces its hard-wired control inputs (RegSrc, ImmSrc, ALUSrc, WE3, PCSrc).

Parameters:
FLAGS_RST, 4'b0000, NZCV value loaded on reset
UNDEF_NOP, 1, 1: Op=2'b11 retires as a no-op; 0: FSM holds in DECODE until reset

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
Cond  input  4  Instr[31:28]
Op  input  2  Instr[27:26]
Funct  input  6  Instr[25:20]: bit 5 = I, bits 4:1 = cmd, bit 0 = S (data-processing) or L (memory)
Rd  input  4  Instr[15:12]
ALUFlags  input  4  {N,Z,C,V} from ALU, current cycle
PCWrite  output  1  PC register enable
AdrSrc  output  1  0: memory address = PC; 1: memory address = ALUOut
MemWrite  output  1  data memory write enable
IRWrite  output  1  instruction register enable
RegWrite  output  1  register file WE3
ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  output  1  0: RD1; 1: PC
ALUSrcB  output  2  00 RD2, 01 ExtImm, 10 constant 4
ALUControl  output  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 PASSB
ImmSrc  output  2  equals Op
RegSrc  output  2  [0] = (Op==10) selects R15 as RA1; [1] = (Op==01 & ~Funct[0]) selects Rd as RA2
Flags  output  4  registered NZCV
Retire  output  1  one-cycle pulse in the final state of each instruction

Behaviour:
- Reset (synchronous, active-high): state=FETCH, Flags=FLAGS_RST, cond_q=0. While reset is high, PCWrite, IRWrite, RegWrite, MemWrite and Retire are forced to 0. Other outputs show FETCH values.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1. Next state DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10. cond_q <= CondEx(Cond, Flags). Next state by opcode:
  - Op=01 -> MEMADR
  - Op=00, Funct[5]=0 -> EXECR
  - Op=00, Funct[5]=1 -> EXECI
  - Op=10 -> BRANCH
  - Op=11 -> FETCH with Retire=1 if UNDEF_NOP=1; otherwise stay in DECODE
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Funct[0]=1 -> MEMREAD, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next state MEMWB.
- MEMWB: ResultSrc=01, RegW. Retire. Next state FETCH.
- MEMWRITE: AdrSrc=1, MemW. Retire. Next state FETCH.
- EXECR: ALUSrcA=0, ALUSrcB=00, ALU decode applies. Next state ALUWB.
- EXECI: same as EXECR but ALUSrcB=01. Next state ALUWB.
- ALUWB: ResultSrc=00, RegW unless NoWrite. Retire. Next state FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, Branch. Retire. Next state FETCH.
- ALU decode, active in EXECR/EXECI only (all other states use ADD):
  - cmd 0100 -> ADD
  - cmd 0010 -> SUB
  - cmd 0000 -> AND
  - cmd 1100 -> ORR
  - cmd 1101 -> PASSB (MOV)
  - cmd 1010 -> SUB with NoWrite (CMP)
  - any other cmd -> ADD with NoWrite, FlagW=00
- Flag write enables: FlagW[1] (N,Z) = S. FlagW[0] (C,V) = S & cmd in {ADD, SUB, CMP}.
- Flag update: Flags update at the clock edge ending EXECR/EXECI when cond_q=1. NZ from FlagW[1], CV from FlagW[0].
- Gating:
  - RegWrite = RegW & cond_q
  - MemWrite = MemW & cond_q
  - PCWrite = FETCH | (cond_q & (Branch | (RegW & Rd==4'hF)))
- A failed condition still walks the full state path and pulses Retire; only the gated enables are suppressed.
- CondEx codes:
  - 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C
  - 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V
  - 8 HI C&~Z; 9 LS ~C|Z; A GE N==V; B LT N!=V
  - C GT ~Z&(N==V); D LE Z|(N!=V); E AL 1; F 0
- Latency per instruction:
  - branch: 3 cycles
  - data-processing: 4 cycles
  - STR: 4 cycles
  - LDR: 5 cycles
- Reset mid-instruction: aborts immediately. No write enable is asserted in the reset cycle. Flags are reloaded from FLAGS_RST.

Decomposition:
- Package arm_ctrl_pkg:
  - state enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH)
  - ALUControl, ResultSrc and ALUSrcB encodings
  - cmd constants
  - cond-code constants
- Sub-module arm_cond_unit: CondEx combinational check, Flags register with FlagW, cond_q register.

Test Plan:
- Reset for 2 cycles, then release -> Flags=0000, state FETCH, IRWrite=1, PCWrite=1; no enable was asserted during reset.
- 0xE3A02005 (MOV R2,#5) -> FETCH, DECODE, EXECI (ALUControl=100, ALUSrcB=01), ALUWB (RegWrite=1); Retire in cycle 4.
- 0xE0824003 (ADD R4,R2,R3) -> EXECR with ALUSrcB=00, ALUControl=000; RegWrite=1 in ALUWB; Flags unchanged (S=0).
- 0xE1520003 (CMP R2,R3) with ALUFlags=0110 -> Flags=0110 after EXECR; RegWrite=0 in ALUWB. Then 0x0A000002 (BEQ) -> BRANCH with PCWrite=1. Then 0x1A000002 (BNE) -> PCWrite=0 in BRANCH, Retire=1.
- LDR 0xE5912004 -> 5 cycles, AdrSrc=1 in MEMREAD, ResultSrc=01 and RegWrite=1 in MEMWB. STR 0xE5812004 -> MemWrite=1 in MEMWRITE, RegSrc=10.
- Assert reset during MEMWRITE -> MemWrite=0 that cycle, next state FETCH, Flags=0000; ADD with Rd=15 -> PCWrite=1 in ALUWB.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// arm_ctrl_pkg
// Shared types and encodings for the ARM-subset multicycle control unit:
//   - state_t      : controller FSM states
//   - ALU_*        : ALUControl encodings
//   - RES_*        : ResultSrc encodings
//   - SRCB_*       : ALUSrcB encodings
//   - CMD_*        : data-processing cmd field values (Instr[24:21])
//   - COND_*       : condition field values (Instr[31:28])
//   - cond_ex()    : condition-field evaluation against NZCV
// ---------------------------------------------------------------------------
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_ORR   = 3'b011;
    localparam logic [2:0] ALU_PASSB = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_EXT  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // nzcv is packed {N,Z,C,V}
    function automatic logic cond_ex(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic r;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: r = z;
            COND_NE: r = ~z;
            COND_CS: r = c;
            COND_CC: r = ~c;
            COND_MI: r = n;
            COND_PL: r = ~n;
            COND_VS: r = v;
            COND_VC: r = ~v;
            COND_HI: r = c & ~z;
            COND_LS: r = ~c | z;
            COND_GE: r = (n == v);
            COND_LT: r = (n != v);
            COND_GT: r = ~z & (n == v);
            COND_LE: r = z | (n != v);
            COND_AL: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/arm_cond_unit.sv
// ---------------------------------------------------------------------------
// arm_cond_unit
// Holds the NZCV flags register and the latched condition result (cond_q).
//   clk, reset : clock, synchronous active-high reset
//   cond       : condition field of the current instruction
//   alu_flags  : {N,Z,C,V} produced by the ALU this cycle
//   flag_w     : [1] writes N,Z  [0] writes C,V
//   flag_en    : high in the execute state; flags update only if cond_q is set
//   cond_we    : high in DECODE; captures cond_ex(cond, flags) into cond_q
//   flags      : registered NZCV
//   cond_q     : condition result for the instruction in flight
// ---------------------------------------------------------------------------
module arm_cond_unit
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       flag_en,
    input  logic       cond_we,
    output logic [3:0] flags,
    output logic       cond_q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            flags  <= FLAGS_RST;
            cond_q <= 1'b0;
        end else begin
            if (cond_we) begin
                cond_q <= cond_ex(cond, flags);
            end
            // A failed condition leaves the flags untouched.
            if (flag_en && cond_q) begin
                if (flag_w[1]) flags[3:2] <= alu_flags[3:2];
                if (flag_w[0]) flags[1:0] <= alu_flags[1:0];
            end
        end
    end

endmodule

// File: rtl/arm_mc_controller.sv
// ---------------------------------------------------------------------------
// arm_mc_controller
// Moore-FSM multicycle control unit for the ARM-subset datapath. Sequences
// each instruction (FETCH, DECODE, then a class-specific path) and drives
// every datapath select and enable; condition evaluation gates the enables.
//   clk, reset            : clock, synchronous active-high reset
//   Cond, Op, Funct, Rd   : instruction fields from the instruction register
//   ALUFlags              : {N,Z,C,V} from the ALU, current cycle
//   PCWrite, IRWrite,
//   RegWrite, MemWrite    : write enables (all low while reset is high)
//   AdrSrc, ResultSrc,
//   ALUSrcA, ALUSrcB,
//   ALUControl, ImmSrc,
//   RegSrc                : datapath mux selects / ALU operation
//   Flags                 : registered NZCV
//   Retire                : one-cycle pulse in each instruction's last state
//   state_dbg             : current FSM state, for observation only
// ---------------------------------------------------------------------------
module arm_mc_controller
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000,
    parameter bit         UNDEF_NOP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] Flags,
    output logic       Retire,
    output logic [3:0] state_dbg
);

    state_t state, next_state, cur;

    logic [3:0] cmd;
    logic       s_bit;
    logic [2:0] alu_dec;
    logic       no_write;
    logic [1:0] flag_w;

    logic regw, memw, branch, irw, retire, is_fetch;
    logic flag_en, cond_we, cond_q;

    assign cmd   = Funct[4:1];
    assign s_bit = Funct[0];

    // Data-processing decode; unknown cmds behave as ADD that writes nothing.
    always_comb begin
        alu_dec  = ALU_ADD;
        no_write = 1'b0;
        flag_w   = 2'b00;
        case (cmd)
            CMD_ADD: begin alu_dec = ALU_ADD;   flag_w = {s_bit, s_bit}; end
            CMD_SUB: begin alu_dec = ALU_SUB;   flag_w = {s_bit, s_bit}; end
            CMD_AND: begin alu_dec = ALU_AND;   flag_w = {s_bit, 1'b0};  end
            CMD_ORR: begin alu_dec = ALU_ORR;   flag_w = {s_bit, 1'b0};  end
            CMD_MOV: begin alu_dec = ALU_PASSB; flag_w = {s_bit, 1'b0};  end
            CMD_CMP: begin alu_dec = ALU_SUB;   flag_w = {s_bit, s_bit}; no_write = 1'b1; end
            default: begin alu_dec = ALU_ADD;   flag_w = 2'b00;          no_write = 1'b1; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    // While reset is high the outputs decode as FETCH; enables are masked below.
    always_comb begin
        cur        = reset ? FETCH : state;
        next_state = cur;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RD2;
        ALUControl = ALU_ADD;
        regw       = 1'b0;
        memw       = 1'b0;
        branch     = 1'b0;
        irw        = 1'b0;
        retire     = 1'b0;
        is_fetch   = 1'b0;
        flag_en    = 1'b0;
        cond_we    = 1'b0;
        case (cur)
            FETCH: begin
                irw        = 1'b1;
                is_fetch   = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                next_state = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                cond_we   = 1'b1;
                case (Op)
                    2'b01:   next_state = MEMADR;
                    2'b00:   next_state = Funct[5] ? EXECI : EXECR;
                    2'b10:   next_state = BRANCH;
                    default: begin
                        if (UNDEF_NOP) begin
                            next_state = FETCH;
                            retire     = 1'b1;
                        end else begin
                            next_state = DECODE;
                        end
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcB    = SRCB_EXT;
                next_state = Funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc     = 1'b1;
                next_state = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = RES_DATA;
                regw       = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                AdrSrc     = 1'b1;
                memw       = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            EXECR: begin
                ALUControl = alu_dec;
                flag_en    = 1'b1;
                next_state = ALUWB;
            end
            EXECI: begin
                ALUSrcB    = SRCB_EXT;
                ALUControl = alu_dec;
                flag_en    = 1'b1;
                next_state = ALUWB;
            end
            ALUWB: begin
                regw       = ~no_write;
                retire     = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                ALUSrcB    = SRCB_EXT;
                ResultSrc  = RES_ALURESULT;
                branch     = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase
    end

    // A register write to R15 redirects the PC.
    assign RegWrite = ~reset & regw & cond_q;
    assign MemWrite = ~reset & memw & cond_q;
    assign PCWrite  = ~reset & (is_fetch | (cond_q & (branch | (regw & (Rd == 4'hF)))));
    assign IRWrite  = ~reset & irw;
    assign Retire   = ~reset & retire;

    assign ImmSrc    = Op;
    assign RegSrc    = {(Op == 2'b01) & ~Funct[0], (Op == 2'b10)};
    assign state_dbg = state;

    arm_cond_unit #(
        .FLAGS_RST(FLAGS_RST)
    ) u_cond (
        .clk      (clk),
        .reset    (reset),
        .cond     (Cond),
        .alu_flags(ALUFlags),
        .flag_w   (flag_w),
        .flag_en  (flag_en),
        .cond_we  (cond_we),
        .flags    (Flags),
        .cond_q   (cond_q)
    );

endmodule

// File: tb/tb_arm_mc_controller.sv
// ---------------------------------------------------------------------------
// tb_arm_mc_controller
// Directed and random instruction streams for arm_mc_controller. For each
// instruction the bench derives, from the instruction class and the
// condition result, the per-cycle control vector, flags and ALUFlags stimulus,
// queues them, then replays the queue one cycle at a time.
// Control vector layout: {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
//                         ResultSrc[1:0], ALUSrcA, ALUSrcB[1:0],
//                         ALUControl[2:0], Retire}
// ---------------------------------------------------------------------------
module tb_arm_mc_controller;

    localparam logic [3:0] FLAGS_RST = 4'b0000;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, Retire;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    logic [3:0] Flags;
    logic [3:0] state_dbg;

    always #5 clk = ~clk;

    arm_mc_controller #(
        .FLAGS_RST(FLAGS_RST),
        .UNDEF_NOP(1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Cond      (Cond),
        .Op        (Op),
        .Funct     (Funct),
        .Rd        (Rd),
        .ALUFlags  (ALUFlags),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUControl(ALUControl),
        .ImmSrc    (ImmSrc),
        .RegSrc    (RegSrc),
        .Flags     (Flags),
        .Retire    (Retire),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [13:0] exp_q[$];
    logic [3:0]  flag_q[$];
    logic [3:0]  stim_q[$];
    logic [3:0]  m_flags;

    function automatic logic [13:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic a, input logic [1:0] b, input logic [2:0] alu,
                                       input logic ret);
        return {pcw, adr, mw, irw, rw, rs, a, b, alu, ret};
    endfunction

    // Condition table folded as base test plus inversion by the low bit.
    function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? ~base : base;
    endfunction

    // ---------------- checkers ----------------
    task automatic check_vec(input string tag, input logic [13:0] exp);
        logic [13:0] got;
        got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, Retire};
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s ctrl: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check4(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // ---------------- driver: one instruction ----------------
    // fix_ex: use ex_flags as ALUFlags in the execute cycle (else random).
    // abort_at: cycle index at which reset is raised (-1 = never).
    task automatic run_instr(input logic [31:0] w, input bit fix_ex, input logic [3:0] ex_flags,
                             input int abort_at, input string tag);
        logic [3:0]  cnd, cmd, rd, af, ef;
        logic [1:0]  op;
        logic [5:0]  fn;
        logic        c, s, known, cv_cmd, wr, r15;
        logic [2:0]  alu;
        logic [13:0] fetch_v, e;
        cnd = w[31:28]; op = w[27:26]; fn = w[25:20]; rd = w[15:12];
        cmd = fn[4:1];  s = fn[0];     r15 = (rd == 4'hF);
        c   = model_cond(cnd, m_flags);

        known = 1'b1; cv_cmd = 1'b0; wr = 1'b1;
        case (cmd)
            4'h4: begin alu = 3'b000; cv_cmd = 1'b1; end
            4'h2: begin alu = 3'b001; cv_cmd = 1'b1; end
            4'h0:       alu = 3'b010;
            4'hC:       alu = 3'b011;
            4'hD:       alu = 3'b100;
            4'hA: begin alu = 3'b001; cv_cmd = 1'b1; wr = 1'b0; end
            default: begin alu = 3'b000; known = 1'b0; wr = 1'b0; end
        endcase

        fetch_v = mk(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 3'b000, 0);
        exp_q.push_back(fetch_v);
        flag_q.push_back(m_flags);
        stim_q.push_back(4'($urandom_range(0, 15)));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 3'b000, op == 2'b11));
        flag_q.push_back(m_flags);
        stim_q.push_back(4'($urandom_range(0, 15)));

        case (op)
            2'b10: begin
                exp_q.push_back(mk(c, 0, 0, 0, 0, 2'b10, 0, 2'b01, 3'b000, 1));
                flag_q.push_back(m_flags);
                stim_q.push_back(4'($urandom_range(0, 15)));
            end
            2'b00: begin
                af = fix_ex ? ex_flags : 4'($urandom_range(0, 15));
                exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, fn[5] ? 2'b01 : 2'b00, alu, 0));
                flag_q.push_back(m_flags);
                stim_q.push_back(af);
                if (c && s && known) m_flags[3:2] = af[3:2];
                if (c && s && cv_cmd) m_flags[1:0] = af[1:0];
                exp_q.push_back(mk(c & wr & r15, 0, 0, 0, c & wr, 2'b00, 0, 2'b00, 3'b000, 1));
                flag_q.push_back(m_flags);
                stim_q.push_back(4'($urandom_range(0, 15)));
            end
            2'b01: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b000, 0));
                flag_q.push_back(m_flags);
                stim_q.push_back(4'($urandom_range(0, 15)));
                if (s) begin
                    exp_q.push_back(mk(0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0));
                    exp_q.push_back(mk(c & r15, 0, 0, 0, c, 2'b01, 0, 2'b00, 3'b000, 1));
                    repeat (2) begin
                        flag_q.push_back(m_flags);
                        stim_q.push_back(4'($urandom_range(0, 15)));
                    end
                end else begin
                    exp_q.push_back(mk(0, 1, c, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1));
                    flag_q.push_back(m_flags);
                    stim_q.push_back(4'($urandom_range(0, 15)));
                end
            end
            default: ;
        endcase

        for (int k = 0; exp_q.size() > 0; k++) begin
            e  = exp_q.pop_front();
            ef = flag_q.pop_front();
            af = stim_q.pop_front();
            @(negedge clk);
            reset = (k == abort_at);
            Cond = cnd; Op = op; Funct = fn; Rd = rd; ALUFlags = af;
            #1;
            if (k == abort_at) begin
                check_vec($sformatf("%s rst_c%0d", tag, k),
                          mk(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 3'b000, 0));
                check4($sformatf("%s rst_flags_c%0d", tag, k), Flags, ef);
                exp_q.delete(); flag_q.delete(); stim_q.delete();
                m_flags = FLAGS_RST;
            end else begin
                check_vec($sformatf("%s c%0d", tag, k), e);
                check4($sformatf("%s flags_c%0d", tag, k), Flags, ef);
                check4($sformatf("%s imm_regsrc_c%0d", tag, k), {ImmSrc, RegSrc},
                       {op, (op == 2'b01) & ~fn[0], op == 2'b10});
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] w;
        int          sel;
        reset = 1'b1; Cond = '0; Op = '0; Funct = '0; Rd = '0; ALUFlags = '0;
        m_flags = FLAGS_RST;

        repeat (2) begin
            @(negedge clk); #1;
            check_vec("reset", mk(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 3'b000, 0));
            check4("reset_flags", Flags, FLAGS_RST);
        end

        run_instr(32'hE3A02005, 1'b0, 4'h0, -1, "mov_imm");
        run_instr(32'hE0824003, 1'b0, 4'h0, -1, "add_reg");
        run_instr(32'hE1520003, 1'b1, 4'b0110, -1, "cmp");
        run_instr(32'h0A000002, 1'b0, 4'h0, -1, "beq");
        run_instr(32'h1A000002, 1'b0, 4'h0, -1, "bne");
        run_instr(32'hE5912004, 1'b0, 4'h0, -1, "ldr");
        run_instr(32'hE5812004, 1'b0, 4'h0, 3, "str_abort");
        run_instr(32'hE082F003, 1'b0, 4'h0, -1, "add_r15");
        run_instr(32'hE5812004, 1'b0, 4'h0, -1, "str");
        run_instr(32'hEC000000, 1'b0, 4'h0, -1, "undef");
        run_instr(32'hE1B22003, 1'b1, 4'b1001, -1, "movs");
        run_instr(32'hE0922003, 1'b1, 4'b0011, -1, "adds");

        for (int i = 0; i < 80; i++) begin
            w   = $urandom;
            sel = $urandom_range(0, 9);
            w[27:26] = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            if ($urandom_range(0, 4) == 0) w[15:12] = 4'hF;
            if ($urandom_range(0, 3) == 0) w[31:28] = 4'hE;
            run_instr(w, 1'b0, 4'h0, ($urandom_range(0, 19) == 0) ? 2 : -1,
                      $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
